// File: rtl/door_lock_param.sv
// Parameterised keypad door lock: edge-detected button digits, sticky mismatch, timeout and lockout.
// Outputs are registered; state changes one cycle after the deciding input.
module door_lock_param #(
    parameter int N_BTN       = 3,
    parameter int CODE_LEN    = 2,
    parameter logic [CODE_LEN*(($clog2(N_BTN) > 1) ? $clog2(N_BTN) : 1)-1:0] CODE = 4'b0010,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYC    = 16,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [N_BTN-1:0]                button,
    output logic [N_BTN-1:0]                led_btn,
    output logic                            led_ok,
    output logic                            led_fail,
    output logic                            led_lock,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);
    localparam int IDXW = ($clog2(N_BTN) > 1) ? $clog2(N_BTN) : 1;
    localparam int FCW  = $clog2(MAX_FAIL+1);
    localparam int DIW  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int TW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int LW   = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

    typedef enum logic [2:0] {IDLE, ENTER, OK, FAIL, LOCK} state_t;

    state_t           state;
    logic [N_BTN-1:0] button_q;
    logic [DIW-1:0]   dig_idx;
    logic             mism;
    logic [TW-1:0]    to_cnt;
    logic [LW-1:0]    lock_cnt;

    logic [N_BTN-1:0] ev;
    logic             any_ev;
    logic [IDXW-1:0]  exp_digit;
    logic             digit_ok;
    logic             last_digit;
    logic             code_ok;
    logic             code_bad;
    logic [FCW-1:0]   fail_inc;
    logic             to_lock;

    always_comb begin
        ev         = button & ~button_q;
        any_ev     = |ev;
        exp_digit  = CODE[int'(dig_idx)*IDXW +: IDXW];
        // Equality with a one-hot word rejects both wrong and simultaneous presses.
        digit_ok   = (ev == (N_BTN'(1) << exp_digit));
        last_digit = (dig_idx == DIW'(CODE_LEN-1));
        code_ok    = any_ev && last_digit && !mism && digit_ok;
        code_bad   = (any_ev && last_digit && (mism || !digit_ok)) ||
                     (!any_ev && (to_cnt == TW'(TIMEOUT_CYC-1)));
        fail_inc   = (fail_cnt == FCW'(MAX_FAIL)) ? fail_cnt : fail_cnt + 1'b1;
        to_lock    = (fail_inc == FCW'(MAX_FAIL));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            button_q <= '0;
            dig_idx  <= '0;
            mism     <= 1'b0;
            to_cnt   <= '0;
            lock_cnt <= '0;
            led_btn  <= '0;
            led_ok   <= 1'b0;
            led_fail <= 1'b0;
            led_lock <= 1'b0;
            fail_cnt <= '0;
        end else begin
            button_q <= button;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ENTER;
                        dig_idx <= '0;
                        mism    <= 1'b0;
                        to_cnt  <= '0;
                    end
                end
                ENTER: begin
                    if (!start) begin
                        state   <= IDLE;
                        led_btn <= '0;
                    end else begin
                        led_btn <= led_btn | ev;
                        if (code_ok) begin
                            state    <= OK;
                            led_ok   <= 1'b1;
                            fail_cnt <= '0;
                        end else if (code_bad) begin
                            fail_cnt <= fail_inc;
                            if (to_lock) begin
                                state    <= LOCK;
                                led_lock <= 1'b1;
                                lock_cnt <= '0;
                            end else begin
                                state    <= FAIL;
                                led_fail <= 1'b1;
                            end
                        end else if (any_ev) begin
                            dig_idx <= dig_idx + 1'b1;
                            mism    <= mism | !digit_ok;
                            to_cnt  <= '0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                OK, FAIL: begin
                    if (!start) begin
                        state    <= IDLE;
                        led_ok   <= 1'b0;
                        led_fail <= 1'b0;
                        led_btn  <= '0;
                    end
                end
                LOCK: begin
                    if (lock_cnt == LW'(LOCK_CYC-1)) begin
                        state    <= IDLE;
                        led_lock <= 1'b0;
                        led_btn  <= '0;
                        fail_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_door_lock_param.sv
// Bench for door_lock_param: directed scenarios plus random stimulus against a session-level model.
module tb_door_lock_param;
    localparam int N_BTN = 3, CODE_LEN = 2, MAX_FAIL = 3, LOCK_CYC = 16, TIMEOUT_CYC = 32;
    localparam int IDXW = 2;
    localparam logic [3:0] CODE_V = 4'b0010;
    localparam int M_IDLE = 0, M_ENTER = 1, M_OK = 2, M_FAIL = 3, M_LOCK = 4;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [2:0] button = '0;
    logic [2:0] led_btn;
    logic led_ok, led_fail, led_lock;
    logic [1:0] fail_cnt;

    door_lock_param #(.N_BTN(N_BTN), .CODE_LEN(CODE_LEN), .CODE(CODE_V), .MAX_FAIL(MAX_FAIL),
                      .LOCK_CYC(LOCK_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst), .start(start), .button(button), .led_btn(led_btn),
        .led_ok(led_ok), .led_fail(led_fail), .led_lock(led_lock), .fail_cnt(fail_cnt));

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: a session is a list of entered digits (-1 = several buttons at once).
    int       m_mode = M_IDLE;
    int       m_digits[$];
    int       m_idle = 0, m_lock_left = 0, m_fails = 0;
    logic [2:0] m_prev = '0, m_leds = '0;

    task automatic m_fail();
        if (m_fails < MAX_FAIL) m_fails++;
        if (m_fails == MAX_FAIL) begin
            m_mode = M_LOCK;
            m_lock_left = LOCK_CYC;
        end else m_mode = M_FAIL;
    endtask

    function automatic bit m_code_matches();
        for (int i = 0; i < CODE_LEN; i++)
            if (m_digits[i] != int'((CODE_V >> (i*IDXW)) & 4'b0011)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_step(input logic r, input logic s, input logic [2:0] b);
        logic [2:0] ev;
        int d;
        if (r) begin
            m_mode = M_IDLE; m_digits.delete(); m_idle = 0; m_lock_left = 0;
            m_fails = 0; m_prev = '0; m_leds = '0;
            return;
        end
        ev = b & ~m_prev;
        m_prev = b;
        case (m_mode)
            M_IDLE: if (s) begin m_mode = M_ENTER; m_digits.delete(); m_idle = 0; end
            M_ENTER: begin
                if (!s) begin m_mode = M_IDLE; m_leds = '0; end
                else if (ev != 0) begin
                    m_leds |= ev;
                    m_idle = 0;
                    d = -1;
                    if ($countones(ev) == 1)
                        for (int k = 0; k < N_BTN; k++) if (ev[k]) d = k;
                    m_digits.push_back(d);
                    if (m_digits.size() == CODE_LEN) begin
                        if (m_code_matches()) begin m_mode = M_OK; m_fails = 0; end
                        else m_fail();
                    end
                end else begin
                    m_idle++;
                    if (m_idle == TIMEOUT_CYC) m_fail();
                end
            end
            M_OK, M_FAIL: if (!s) begin m_mode = M_IDLE; m_leds = '0; end
            M_LOCK: begin
                m_lock_left--;
                if (m_lock_left == 0) begin m_mode = M_IDLE; m_fails = 0; m_leds = '0; end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic cycle(input logic r, input logic s, input logic [2:0] b);
        rst = r; start = s; button = b;
        @(posedge clk);
        m_step(r, s, b);
        @(negedge clk);
        check("led_btn",  32'(led_btn),  32'(m_leds));
        check("led_ok",   32'(led_ok),   32'(m_mode == M_OK));
        check("led_fail", 32'(led_fail), 32'(m_mode == M_FAIL));
        check("led_lock", 32'(led_lock), 32'(m_mode == M_LOCK));
        check("fail_cnt", 32'(fail_cnt), 32'(m_fails));
    endtask

    task automatic wrong_session();
        cycle(0, 1, 3'b000);
        cycle(0, 1, 3'b001);
        cycle(0, 1, 3'b000);
        cycle(0, 1, 3'b001);
    endtask

    int lock_len;
    logic [2:0] rb;

    initial begin
        cycle(1, 0, 3'b000);
        cycle(1, 1, 3'b111);
        check("reset_leds", 32'({led_btn, led_ok, led_fail, led_lock}), 32'h0);
        check("reset_fcnt", 32'(fail_cnt), 32'h0);

        // Correct code: b2 then b0.
        cycle(0, 1, 3'b000);
        cycle(0, 1, 3'b100);
        cycle(0, 1, 3'b000);
        cycle(0, 1, 3'b001);
        check("ok_led", 32'(led_ok), 32'h1);
        check("ok_btn", 32'(led_btn), 32'h5);
        check("ok_fcnt", 32'(fail_cnt), 32'h0);
        cycle(0, 0, 3'b000);
        check("ok_clear", 32'({led_btn, led_ok, led_fail, led_lock}), 32'h0);

        // Wrong order: no early exit after the first digit.
        cycle(0, 1, 3'b000);
        cycle(0, 1, 3'b001);
        check("no_early_exit", 32'({led_ok, led_fail}), 32'h0);
        cycle(0, 1, 3'b000);
        cycle(0, 1, 3'b100);
        check("wrong_fail", 32'(led_fail), 32'h1);
        check("wrong_fcnt", 32'(fail_cnt), 32'h1);
        cycle(0, 0, 3'b000);

        // Two more failures lead to lockout that ignores start and buttons.
        wrong_session();
        cycle(0, 0, 3'b000);
        wrong_session();
        check("lock_enter", 32'(led_lock), 32'h1);
        check("lock_fcnt", 32'(fail_cnt), 32'h3);
        lock_len = 1;
        for (int i = 0; i < 40 && led_lock; i++) begin
            cycle(0, 1, 3'($urandom_range(0, 7)));
            if (led_lock) lock_len++;
        end
        check("lock_len", 32'(lock_len), 32'(LOCK_CYC));
        check("lock_exit_fcnt", 32'(fail_cnt), 32'h0);
        cycle(0, 0, 3'b000);
        cycle(0, 0, 3'b000);

        // Timeout after one digit.
        cycle(0, 1, 3'b000);
        cycle(0, 1, 3'b100);
        for (int i = 0; i < TIMEOUT_CYC - 1; i++) cycle(0, 1, 3'b000);
        check("timeout_early", 32'(led_fail), 32'h0);
        cycle(0, 1, 3'b000);
        check("timeout_fail", 32'(led_fail), 32'h1);
        check("timeout_fcnt", 32'(fail_cnt), 32'h1);
        cycle(0, 0, 3'b000);

        // Simultaneous presses count as a mismatching digit.
        cycle(0, 1, 3'b000);
        cycle(0, 1, 3'b110);
        cycle(0, 1, 3'b000);
        cycle(0, 1, 3'b001);
        check("multi_fail", 32'(led_fail), 32'h1);
        check("multi_fcnt", 32'(fail_cnt), 32'h2);
        cycle(0, 0, 3'b000);

        // A button already held when the session opens is not a digit.
        cycle(0, 0, 3'b100);
        cycle(0, 1, 3'b100);
        cycle(0, 1, 3'b100);
        check("held_btn", 32'(led_btn), 32'h0);
        cycle(0, 1, 3'b000);
        cycle(0, 1, 3'b100);
        cycle(0, 1, 3'b000);
        cycle(0, 1, 3'b001);
        check("held_then_ok", 32'(led_ok), 32'h1);
        cycle(0, 0, 3'b000);

        // Reset in the middle of a session.
        cycle(0, 1, 3'b000);
        cycle(0, 1, 3'b100);
        check("pre_rst_btn", 32'(led_btn), 32'h4);
        cycle(1, 1, 3'b000);
        check("mid_rst", 32'({led_btn, led_ok, led_fail, led_lock, fail_cnt}), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 19))
                0, 1, 2, 3, 4, 5, 6, 7, 8, 9: rb = 3'b000;
                10, 11, 12, 13, 14, 15, 16:   rb = 3'b001 << $urandom_range(0, 2);
                default:                      rb = 3'($urandom_range(0, 7));
            endcase
            cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) != 0), rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/door_lock_param.md
DOOR_LOCK_PARAM -- requirements
Module: door_lock_param

Interface
REQ-001 SHALL have parameter N_BTN, default 3, number of code buttons (2..16).
REQ-002 SHALL have parameter CODE_LEN, default 2, number of digits per code (1..8).
REQ-003 SHALL have parameter CODE, default 4'b0010, packed digits of IDXW=max(1,clog2(N_BTN)) bits each; digit i at CODE[i*IDXW +: IDXW], digit 0 entered first (default sequence: button 2, then button 0).
REQ-004 SHALL have parameter MAX_FAIL, default 3, consecutive failures that trigger lockout.
REQ-005 SHALL have parameter LOCK_CYC, default 16, lockout duration in clk cycles.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 32, maximum idle cycles between digits.
REQ-007 clk  input  1  sole clock; all logic on rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 start  input  1  session enable level.
REQ-010 button  input  N_BTN  raw button levels, bit k = button k.
REQ-011 led_btn  output  N_BTN  per-button "pressed this session" indicators.
REQ-012 led_ok  output  1  code accepted.
REQ-013 led_fail  output  1  code rejected.
REQ-014 led_lock  output  1  lockout active.
REQ-015 fail_cnt  output  clog2(MAX_FAIL+1)  consecutive failure count.

Function
REQ-016 SHALL implement states IDLE, ENTER, OK, FAIL, LOCK; all outputs SHALL be driven from registers.
REQ-017 SHALL register button every cycle into button_q; press event = button & ~button_q, so a button held across a cycle counts once and a press already high before ENTER is ignored.
REQ-018 IDLE: start=1 -> ENTER next cycle; digit index, mismatch flag, timeout counter cleared on entry.
REQ-019 ENTER: a cycle with any press event consumes one digit; digit matches only if exactly one event is set and its index equals the expected CODE digit; multiple simultaneous events = mismatch.
REQ-020 ENTER: a mismatch SHALL set a sticky flag without early exit; decision is made only after CODE_LEN digits (no length leak).
REQ-021 On the CODE_LEN-th digit: all matched -> OK next cycle, fail_cnt <= 0; else failure path (REQ-023).
REQ-022 ENTER: timeout counter resets on each digit; reaching TIMEOUT_CYC cycles without a digit SHALL take the failure path.
REQ-023 Failure path: fail_cnt <= fail_cnt+1; if the new value equals MAX_FAIL -> LOCK, else -> FAIL.
REQ-024 ENTER with start=0 -> IDLE; digits discarded; fail_cnt unchanged.
REQ-025 OK / FAIL: remain while start=1; start=0 -> IDLE.
REQ-026 LOCK: start and button ignored; lock counter counts LOCK_CYC cycles, then IDLE with fail_cnt <= 0.
REQ-027 led_btn[k] SHALL set on a press event of button k in ENTER, hold through OK/FAIL/LOCK, clear on entering IDLE.
REQ-028 led_ok=1 iff state OK; led_fail=1 iff state FAIL; led_lock=1 iff state LOCK.
REQ-029 fail_cnt SHALL saturate at MAX_FAIL and never wrap.

Reset
REQ-030 rst=1 at a clk edge SHALL force IDLE, clear digit index, flags, counters, button_q, fail_cnt and all LEDs to 0 regardless of state, including mid-ENTER or mid-LOCK.

Verification
REQ-031 rst pulse during ENTER with led_btn=3'b100 -> next cycle all outputs 0, state IDLE.
REQ-032 start=1; press b2 one cycle; release; press b0 -> led_ok=1 cycle after b0 edge, led_btn=3'b101, fail_cnt=0; start=0 -> all LEDs 0.
REQ-033 start=1; press b0 then b2 -> no exit after first digit; led_fail=1 after second, fail_cnt=1.
REQ-034 Three consecutive wrong sessions -> third enters LOCK, led_lock=1 for exactly 16 cycles with start=1 and random presses ignored, then IDLE, fail_cnt=0.
REQ-035 start=1; press b2; no presses for 32 cycles -> led_fail=1, fail_cnt incremented.
REQ-036 Press b1 and b2 same cycle as first digit, then b0 -> led_fail=1; button held high across start -> no digit consumed.
